out_buf_writer: RTL and testbench
=================================

OUT_BUF_WRITER -- requirements
Module: out_buf_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 768, meaning the number of buffer entries per frame.
REQ-002 The block SHALL have parameter ADDR_BITS, default 10, meaning the width of the buffer address.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a pulse that begins filling one frame.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels the frame in progress.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_data, input, 24 bits: signed Q16.8 sample.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 The block SHALL have port release, input, 1 bit: the reader has consumed the frame.
REQ-011 The block SHALL have port Outa, output, ADDR_BITS bits: buffer write address.
REQ-012 The block SHALL have port Outd, output, 16 bits: buffer write data.
REQ-013 The block SHALL have port OutBufWea, output, 1 bit: buffer write enable.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last write of a frame.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The block SHALL implement the FSM states IDLE, FILL, DONE and FULL.
REQ-017 IDLE SHALL go to FILL on start, with wr_ptr cleared to 0.
REQ-018 FILL SHALL go to DONE when the handshake at wr_ptr==DEPTH-1 completes.
REQ-019 DONE SHALL go to FULL unconditionally after one cycle.
REQ-020 FULL SHALL go to IDLE on release.
REQ-021 in_ready SHALL be high only in FILL, driven combinationally from the state.
REQ-022 A handshake SHALL be in_valid&&in_ready; each handshake SHALL register Outa=wr_ptr, Outd=converted in_data and OutBufWea=1 on the next edge, giving a latency of 1 cycle.
REQ-023 OutBufWea SHALL be 0 in every cycle that follows a cycle without a handshake.
REQ-024 wr_ptr SHALL increment by 1 per handshake and SHALL wrap from DEPTH-1 to 0.
REQ-025 frame_done SHALL be high for exactly the cycle the FSM is in DONE, which coincides with OutBufWea for the last sample.
REQ-026 The default conversion SHALL be Outd=in_data[23:8], i.e. truncation.
REQ-027 abort SHALL take the FSM from any state to IDLE, clear wr_ptr, and suppress the handshake and write in that cycle; abort SHALL take priority over start and release.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 release outside FULL SHALL be ignored.
REQ-030 start and release asserted together in FULL SHALL go to IDLE only; the start SHALL NOT be retained.
REQ-031 in_valid outside FILL SHALL produce no write and no state change.

Reset
REQ-032 Reset SHALL force state=IDLE, wr_ptr=0, Outa=0, Outd=0, OutBufWea=0 and frame_done=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame, with no further writes until the next start.

Configuration
REQ-034 When OUTBUF_SAT_EN is defined, the conversion SHALL round half-up (add in_data[7]) and saturate to 16'h7FFF / 16'h8000 on signed overflow.
REQ-035 When OUTBUF_SAT_EN is not defined, the conversion SHALL be plain truncation per REQ-026 and the rounding and saturation logic SHALL be absent.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, the DEPTH default (768) and the Q16.8 format constants.
REQ-037 The conversion SHALL be a sub-module, sample_quantize (24-bit in, 16-bit out), wrapping the OUTBUF_SAT_EN variants.

Verification
REQ-038 Full frame: reset, start, then 768 back-to-back valid samples with in_data=n<<8 -> Outa 0..767 and Outd 0..767 one cycle later, frame_done pulses once, busy stays high until release.
REQ-039 Gapped input: in_valid toggling 1,0,1 -> exactly two writes at addresses 0 and 1, with OutBufWea low in the gap cycle.
REQ-040 Abort: abort at wr_ptr=300 -> no write that cycle, state=IDLE; the next start rewrites from Outa=0.
REQ-041 Ignored controls: start in FULL -> ignored; release in FILL -> ignored; start+release in FULL -> IDLE, and no FILL without a new start.
REQ-042 Conversion with OUTBUF_SAT_EN: in_data=24'h7FFFC0 -> Outd=16'h7FFF; 24'h000180 -> 16'h0002. Without OUTBUF_SAT_EN: 24'h000180 -> 16'h0001.
REQ-043 Async reset: reset asserted mid-FILL, between clock edges -> all outputs 0 immediately, with no write on the following edge.

Source files
------------

// File: rtl/out_buf_writer_pkg.sv
// Shared definitions for the output buffer writer: FSM states, frame depth
// default and the Q16.8 -> 16-bit sample format constants.
package out_buf_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } obw_state_e;

    localparam int unsigned OBW_DEPTH_DEFAULT = 768;

    // Q16.8 input sample and 16-bit integer output sample
    localparam int unsigned Q_IN_BITS   = 24;
    localparam int unsigned Q_FRAC_BITS = 8;
    localparam int unsigned Q_OUT_BITS  = 16;
    localparam logic [Q_OUT_BITS-1:0] Q_OUT_MAX = 16'h7FFF;
    localparam logic [Q_OUT_BITS-1:0] Q_OUT_MIN = 16'h8000;

endpackage

// File: rtl/out_buf_writer_sample_quantize.sv
// Q16.8 -> 16-bit sample conversion.
// OUTBUF_SAT_EN defined  : round half-up, saturate to 7FFF/8000 on overflow.
// OUTBUF_SAT_EN undefined: plain truncation (drop the 8 fraction bits).
module sample_quantize
    import out_buf_writer_pkg::*;
(
    input  logic [23:0] in_data_i,
    output logic [15:0] out_data_o
);

`ifdef OUTBUF_SAT_EN
    logic [16:0] rnd;
    logic        unused_frac;

    assign rnd         = {in_data_i[23], in_data_i[23:8]} + {16'b0, in_data_i[7]};
    assign unused_frac = ^in_data_i[6:0];

    // Clamp when the sign-extended rounded value no longer fits 16 bits
    always_comb begin
        out_data_o = rnd[15:0];
        if (rnd[16] != rnd[15]) begin
            out_data_o = rnd[16] ? Q_OUT_MIN : Q_OUT_MAX;
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^in_data_i[Q_FRAC_BITS-1:0];
    assign out_data_o  = in_data_i[Q_IN_BITS-1:Q_FRAC_BITS];
`endif

endmodule

// File: rtl/out_buf_writer.sv
// Frame writer: accepts DEPTH samples per frame after a start pulse and
// writes them, quantized, to a buffer with one cycle of latency.
// Optional OUTBUF_SAT_EN selects rounding/saturating conversion.
// The reader-release input is named release_i because "release" is a
// reserved word.
module out_buf_writer
    import out_buf_writer_pkg::*;
#(
    parameter int unsigned DEPTH     = OBW_DEPTH_DEFAULT,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [23:0]          in_data,
    output logic                 in_ready,
    input  logic                 release_i,
    output logic [ADDR_BITS-1:0] Outa,
    output logic [15:0]          Outd,
    output logic                 OutBufWea,
    output logic                 frame_done,
    output logic                 busy
);

    obw_state_e           state_q;
    logic [ADDR_BITS-1:0] wr_ptr_q;
    logic [ADDR_BITS-1:0] wr_ptr_d;
    logic [ADDR_BITS-1:0] outa_q;
    logic [15:0]          outd_q;
    logic                 wea_q;
    logic                 done_q;
    logic [15:0]          conv_data;
    logic                 last_slot;

    sample_quantize u_quant (
        .in_data_i  (in_data),
        .out_data_o (conv_data)
    );

    assign last_slot = (wr_ptr_q == ADDR_BITS'(DEPTH - 1));
    assign wr_ptr_d  = last_slot ? '0 : wr_ptr_q + ADDR_BITS'(1);

    // Frame FSM with registered buffer-write and frame_done outputs
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            outa_q   <= '0;
            outd_q   <= '0;
            wea_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wea_q  <= 1'b0;
            done_q <= 1'b0;
            if (abort) begin
                state_q  <= ST_IDLE;
                wr_ptr_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q  <= ST_FILL;
                            wr_ptr_q <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (in_valid) begin
                            outa_q   <= wr_ptr_q;
                            outd_q   <= conv_data;
                            wea_q    <= 1'b1;
                            wr_ptr_q <= wr_ptr_d;
                            if (last_slot) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_FULL;
                    end
                    ST_FULL: begin
                        if (release_i) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready   = (state_q == ST_FILL);
    assign busy       = (state_q != ST_IDLE);
    assign Outa       = outa_q;
    assign Outd       = outd_q;
    assign OutBufWea  = wea_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_out_buf_writer.sv
// Self-checking bench for out_buf_writer: behavioural frame model checked
// every cycle, plus directed literal checks on key cycles.
module tb_out_buf_writer;

    localparam int DEPTH     = 768;
    localparam int ADDR_BITS = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 in_valid = 1'b0;
    logic [23:0]          in_data = '0;
    logic                 rel = 1'b0;
    logic                 in_ready;
    logic [ADDR_BITS-1:0] Outa;
    logic [15:0]          Outd;
    logic                 OutBufWea;
    logic                 frame_done;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    out_buf_writer #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .sys_clk    (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .release_i  (rel),
        .Outa       (Outa),
        .Outd       (Outd),
        .OutBufWea  (OutBufWea),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion from Q16.8 arithmetic value
    function automatic logic [15:0] conv_model(input logic [23:0] d);
        int s;
        int r;
        s = $signed(d);
`ifdef OUTBUF_SAT_EN
        r = (s + 128) >>> 8;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`else
        r = s >>> 8;
`endif
        return r[15:0];
    endfunction

    // Behavioural model: frame collecting / completion pulse / awaiting release
    bit          collecting = 0;
    bit          pulse = 0;
    bit          awaiting = 0;
    int          accepted = 0;
    bit          exp_wea = 0;
    int          exp_addr = 0;
    logic [15:0] exp_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            collecting = 0; pulse = 0; awaiting = 0; accepted = 0;
            exp_wea = 0; exp_addr = 0; exp_data = '0;
        end else begin
            exp_wea = 0;
            if (abort) begin
                collecting = 0; pulse = 0; awaiting = 0; accepted = 0;
            end else if (collecting) begin
                if (in_valid) begin
                    exp_wea  = 1;
                    exp_addr = accepted;
                    exp_data = conv_model(in_data);
                    accepted++;
                    if (accepted == DEPTH) begin
                        collecting = 0;
                        pulse      = 1;
                        accepted   = 0;
                    end
                end
            end else if (pulse) begin
                pulse    = 0;
                awaiting = 1;
            end else if (awaiting) begin
                if (rel) awaiting = 0;
            end else if (start) begin
                collecting = 1;
                accepted   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("wea", {31'b0, OutBufWea}, {31'b0, exp_wea});
            chk("frame_done", {31'b0, frame_done}, {31'b0, pulse});
            chk("busy", {31'b0, busy}, {31'b0, collecting | pulse | awaiting});
            chk("in_ready", {31'b0, in_ready}, {31'b0, collecting});
            if (exp_wea) begin
                chk("Outa", 32'(Outa), 32'(exp_addr[ADDR_BITS-1:0]));
                chk("Outd", 32'(Outd), 32'(exp_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; in_valid = 0; rel = 0; in_data = '0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    // Feed n consecutive valid samples with value (base+k)<<8
    task automatic feed(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            in_valid = 1;
            in_data  = 24'((base + k) << 8);
            tick();
        end
        in_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        checking = 1;
        chk("rst_Outa", 32'(Outa), 32'd0);
        chk("rst_Outd", 32'(Outd), 32'd0);
        chk("rst_wea", {31'b0, OutBufWea}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);

        // Full frame of DEPTH back-to-back samples
        pulse_start();
        in_valid = 1; in_data = 24'h0;
        tick();
        chk("first_wea", {31'b0, OutBufWea}, 32'd1);
        chk("first_Outa", 32'(Outa), 32'd0);
        feed(DEPTH - 2, 1);
        in_valid = 1; in_data = 24'(767 << 8);
        tick();
        in_valid = 0;
        chk("last_Outa", 32'(Outa), 32'd767);
        chk("last_Outd", 32'(Outd), 32'd767);
        chk("last_done", {31'b0, frame_done}, 32'd1);
        tick();
        chk("after_done", {31'b0, frame_done}, 32'd0);
        chk("full_busy", {31'b0, busy}, 32'd1);
        // start while full is ignored
        pulse_start();
        repeat (2) tick();
        chk("full_start_ign", {31'b0, busy}, 32'd1);
        rel = 1; tick(); rel = 0;
        chk("released", {31'b0, busy}, 32'd0);
        tick();

        // Gapped input 1,0,1
        pulse_start();
        in_valid = 1; in_data = 24'h000A00; tick();
        in_valid = 0; tick();
        chk("gap_wea", {31'b0, OutBufWea}, 32'd0);
        in_valid = 1; in_data = 24'h000B00; tick();
        in_valid = 0; tick();
        chk("gap2_Outa", 32'(Outa), 32'd1);
        chk("gap2_Outd", 32'(Outd), 32'h000B);
        abort = 1; tick(); abort = 0;

        // Abort at wr_ptr = 300
        pulse_start();
        feed(300, 0);
        abort = 1; in_valid = 1; in_data = 24'h123400; tick();
        abort = 0; in_valid = 0;
        chk("abort_wea", {31'b0, OutBufWea}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        tick();
        pulse_start();
        feed(1, 5);
        chk("restart_Outa", 32'(Outa), 32'd0);

        // Release during fill is ignored; then start+release together in FULL
        rel = 1; tick(); rel = 0;
        chk("rel_in_fill", {31'b0, in_ready}, 32'd1);
        feed(DEPTH - 1, 6);
        tick();
        start = 1; rel = 1; tick(); start = 0; rel = 0;
        chk("start_rel_idle", {31'b0, busy}, 32'd0);
        feed(3, 9);
        chk("no_fill", {31'b0, in_ready}, 32'd0);
        tick();

        // Conversion corner values
        pulse_start();
        in_valid = 1; in_data = 24'h000180; tick();
`ifdef OUTBUF_SAT_EN
        chk("conv_180", 32'(Outd), 32'h0002);
`else
        chk("conv_180", 32'(Outd), 32'h0001);
`endif
        in_data = 24'h7FFFC0; tick();
        chk("conv_7FFFC0", 32'(Outd), 32'h7FFF);
        in_data = 24'hFF8040; tick();
        chk("conv_neg", 32'(Outd), 32'hFF80);
        in_data = 24'h800000; tick();
        chk("conv_min", 32'(Outd), 32'h8000);
        in_valid = 0;
        tick();

        // Async reset between edges mid-fill
        in_valid = 1; in_data = 24'h004400; tick();
        #3 reset = 1;
        #1;
        chk("arst_wea", {31'b0, OutBufWea}, 32'd0);
        chk("arst_Outa", 32'(Outa), 32'd0);
        chk("arst_Outd", 32'(Outd), 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd0);
        tick();
        reset = 0;
        tick();
        chk("post_rst_wea", {31'b0, OutBufWea}, 32'd0);
        tick();
        in_valid = 0;
        repeat (2) tick();

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
